inst_decode_stage: RTL and testbench
====================================

INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

Interface
REQ-001 Parameter INST_W, default 32, instruction width in bits.
REQ-002 Parameter REG_W, default 5, register/condition field width.
REQ-003 Parameter IMM_W, default 16, immediate field width, taken from inst[INST_W-1 -: IMM_W].
REQ-004 Parameter DATA_W, default 32, output immediate width, DATA_W >= IMM_W.
REQ-005 Parameter SIGN_EXT, default 1: 1 = sign-extend immediate, 0 = zero-extend.
REQ-006 Parameter DEPTH, default 2, output buffer entries, power of two, >= 2; requires INST_W >= 6+3*REG_W.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous and active-low.
REQ-009 flush  input  1  synchronous discard of all buffered entries.
REQ-010 in_valid  input  1  in_inst valid this cycle.
REQ-011 in_ready  output  1  stage accepts an instruction this cycle.
REQ-012 in_inst  input  INST_W  raw instruction.
REQ-013 out_valid  output  1  head entry valid.
REQ-014 out_ready  input  1  consumer takes head entry this cycle.
REQ-015 out_type  output  2  inst[1:0] of head entry.
REQ-016 out_src1, out_src2, out_dest, out_cond  output  REG_W each  decoded register fields.
REQ-017 out_imm  output  DATA_W  extended immediate.

Function
REQ-018 Fields: F1 = inst[6 +: REG_W], F2 = inst[6+REG_W +: REG_W], F3 = inst[6+2*REG_W +: REG_W], IMM = inst[INST_W-1 -: IMM_W].
REQ-019 src1 SHALL be F1 for every type.
REQ-020 Type 00: src2, dest, cond, imm all zero.
REQ-021 Type 01: src2 = F2, dest = F3; cond and imm zero.
REQ-022 Type 10: dest = F3, imm = extended IMM; src2 and cond zero.
REQ-023 Type 11: cond = F2, imm = extended IMM; src2 and dest zero.
REQ-024 Decode SHALL be applied at push; the buffer stores decoded fields, not raw instructions.
REQ-025 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-026 in_ready SHALL equal (count != DEPTH), driven from registered state only, independent of out_ready.
REQ-027 out_valid SHALL equal (count != 0); outputs show the oldest entry; outputs hold stable while out_valid && !out_ready.
REQ-028 Latency: instruction pushed in cycle N is presented at earliest in cycle N+1; no combinational in-to-out path.
REQ-029 Simultaneous push and pop SHALL leave count unchanged and preserve order; full throughput of one instruction per cycle.
REQ-030 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-031 Output fields when out_valid = 0 SHALL be zero.
REQ-032 flush = 1: at next edge count, pointers cleared; any push or pop that cycle is discarded; flush has priority over both.

Reset
REQ-033 rst_n low SHALL immediately clear count and pointers; out_valid = 0, all output fields = 0, in_ready = 1 while in reset.
REQ-034 Reset asserted mid-operation SHALL drop all buffered entries; first valid output after release comes from a push after release.

Verification (REG_W=5, INST_W=32, IMM_W=16, DATA_W=32, SIGN_EXT=1, DEPTH=2 unless stated)
REQ-035 Push 0x800100C2 into empty stage, out_ready=1 -> next cycle out_valid=1, type=2, src1=3, dest=1, imm=0xFFFF8001, src2=0, cond=0; same with SIGN_EXT=0 -> imm=0x00008001.
REQ-036 Push 0x00093901 -> type=1, src1=4, src2=7, dest=9, cond=0, imm=0; push 0x00102883 -> type=3, src1=2, cond=5, imm=0x00000010, dest=0.
REQ-037 out_ready=0, push three back-to-back -> in_ready drops after second push, third held; raise out_ready -> entries emerge in order, third accepted in the cycle a slot frees.
REQ-038 Full (count=2), flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, nothing popped or pushed.
REQ-039 Stream 8 instructions with out_ready=1 continuously -> one output per cycle after 1-cycle latency, pointers wrap, order intact.
REQ-040 Assert rst_n=0 mid-stream between clock edges -> out_valid and all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/inst_decode_stage.sv
// Instruction decode stage.
// Splits a raw instruction into type, register fields and an extended
// immediate at push time, then buffers the decoded entries in a small
// circular FIFO so the consumer can stall without stalling decode.
// in_ready depends only on the occupancy register, so there is no
// combinational ready path from out_ready back to in_ready.

module inst_decode_stage #(
   parameter int INST_W   = 32,
   parameter int REG_W    = 5,
   parameter int IMM_W    = 16,
   parameter int DATA_W   = 32,
   parameter bit SIGN_EXT = 1'b1,
   parameter int DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_type,
   output logic [REG_W-1:0]  out_src1,
   output logic [REG_W-1:0]  out_src2,
   output logic [REG_W-1:0]  out_dest,
   output logic [REG_W-1:0]  out_cond,
   output logic [DATA_W-1:0] out_imm
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   // One decoded buffer entry
   typedef struct packed {
      logic [1:0]        typ;
      logic [REG_W-1:0]  src1;
      logic [REG_W-1:0]  src2;
      logic [REG_W-1:0]  dest;
      logic [REG_W-1:0]  cond;
      logic [DATA_W-1:0] imm;
   } entry_t;

   entry_t            mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;

   logic              push_s;
   logic              pop_s;
   entry_t            push_entry_s;
   logic [REG_W-1:0]  f1_s;
   logic [REG_W-1:0]  f2_s;
   logic [REG_W-1:0]  f3_s;
   logic [IMM_W-1:0]  imm_raw_s;
   logic [DATA_W-1:0] imm_ext_s;
   logic              unused_opcode_bits_s;

   // Opcode bits between the type field and F1 carry no decoded meaning
   assign unused_opcode_bits_s = ^in_inst[5:2];

   // Handshake qualifiers, derived only from registered occupancy
   always_comb begin
      in_ready  = (count_r != CNT_W'(DEPTH));
      out_valid = (count_r != {CNT_W{1'b0}});
      push_s    = in_valid & in_ready;
      pop_s     = out_valid & out_ready;
   end

   // Field extraction and immediate extension of the incoming instruction
   always_comb begin
      f1_s      = in_inst[6 +: REG_W];
      f2_s      = in_inst[6 + REG_W +: REG_W];
      f3_s      = in_inst[6 + 2*REG_W +: REG_W];
      imm_raw_s = in_inst[INST_W-1 -: IMM_W];
      imm_ext_s = {DATA_W{SIGN_EXT & imm_raw_s[IMM_W-1]}};
      imm_ext_s[IMM_W-1:0] = imm_raw_s;
   end

   // Type-dependent field routing; unused fields of each type are zero
   always_comb begin
      push_entry_s      = '0;
      push_entry_s.typ  = in_inst[1:0];
      push_entry_s.src1 = f1_s;
      case (in_inst[1:0])
         2'b00: begin
            push_entry_s.src2 = {REG_W{1'b0}};
         end
         2'b01: begin
            push_entry_s.src2 = f2_s;
            push_entry_s.dest = f3_s;
         end
         2'b10: begin
            push_entry_s.dest = f3_s;
            push_entry_s.imm  = imm_ext_s;
         end
         2'b11: begin
            push_entry_s.cond = f2_s;
            push_entry_s.imm  = imm_ext_s;
         end
         default: begin
            push_entry_s = '0;
         end
      endcase
   end

   // Entry storage; contents are masked at the output whenever count is zero
   always_ff @(posedge clk) begin
      if (push_s && !flush) begin
         mem_r[wr_ptr_r] <= push_entry_s;
      end
   end

   // Occupancy and pointer bookkeeping; flush beats push and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Head entry presentation, forced to zero while the buffer is empty
   always_comb begin
      out_type = 2'b00;
      out_src1 = {REG_W{1'b0}};
      out_src2 = {REG_W{1'b0}};
      out_dest = {REG_W{1'b0}};
      out_cond = {REG_W{1'b0}};
      out_imm  = {DATA_W{1'b0}};
      if (out_valid) begin
         out_type = mem_r[rd_ptr_r].typ;
         out_src1 = mem_r[rd_ptr_r].src1;
         out_src2 = mem_r[rd_ptr_r].src2;
         out_dest = mem_r[rd_ptr_r].dest;
         out_cond = mem_r[rd_ptr_r].cond;
         out_imm  = mem_r[rd_ptr_r].imm;
      end else begin
         out_type = 2'b00;
      end
   end

   inst_decode_stage_chk #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_chk (
      .clk     (clk),
      .rst_n   (rst_n),
      .count_r (count_r),
      .push_s  (push_s),
      .pop_s   (pop_s)
   );

endmodule

// Occupancy invariants of the decode buffer.
module inst_decode_stage_chk #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input logic             clk,
   input logic             rst_n,
   input logic [CNT_W-1:0] count_r,
   input logic             push_s,
   input logic             pop_s
);

   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      count_r <= CNT_W'(DEPTH));

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      (count_r == CNT_W'(DEPTH)) |-> !push_s);

   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
      (count_r == {CNT_W{1'b0}}) |-> !pop_s);

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: a sign-extending and a zero-extending
// instance share stimulus; a queue model tracks accepted instructions
// and every falling edge compares both heads against it.

module tb_inst_decode_stage;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_inst;
   logic        out_ready;

   logic        in_ready,  out_valid;
   logic [1:0]  out_type;
   logic [4:0]  out_src1, out_src2, out_dest, out_cond;
   logic [31:0] out_imm;

   logic        in_ready_z, out_valid_z;
   logic [1:0]  out_type_z;
   logic [4:0]  out_src1_z, out_src2_z, out_dest_z, out_cond_z;
   logic [31:0] out_imm_z;

   int checks = 0;
   int errors = 0;

   logic [31:0] q[$];

   inst_decode_stage #(.SIGN_EXT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_type(out_type), .out_src1(out_src1), .out_src2(out_src2),
      .out_dest(out_dest), .out_cond(out_cond), .out_imm(out_imm)
   );

   inst_decode_stage #(.SIGN_EXT(1'b0)) dut_z (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_z), .in_inst(in_inst),
      .out_valid(out_valid_z), .out_ready(out_ready),
      .out_type(out_type_z), .out_src1(out_src1_z), .out_src2(out_src2_z),
      .out_dest(out_dest_z), .out_cond(out_cond_z), .out_imm(out_imm_z)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode written straight from the field definitions
   function automatic logic [53:0] model(input logic [31:0] i, input bit sext);
      logic [1:0]  t;
      logic [4:0]  s1, s2, d, c;
      logic [31:0] im;
      t  = i[1:0];
      s1 = i[10:6];
      s2 = 5'd0;
      d  = 5'd0;
      c  = 5'd0;
      im = sext ? {{16{i[31]}}, i[31:16]} : {16'h0000, i[31:16]};
      case (t)
         2'b00: im = 32'd0;
         2'b01: begin s2 = i[15:11]; d = i[20:16]; im = 32'd0; end
         2'b10: d = i[20:16];
         2'b11: c = i[15:11];
         default: im = 32'd0;
      endcase
      return {t, s1, s2, d, c, im};
   endfunction

   // Scoreboard model of the buffer: push/pop/flush/reset
   always @(posedge clk or negedge rst_n) begin
      bit pop_m;
      bit push_m;
      if (!rst_n) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else begin
         pop_m  = (q.size() != 0) && out_ready;
         push_m = in_valid && (q.size() != DEPTH);
         if (pop_m) void'(q.pop_front());
         if (push_m) q.push_back(in_inst);
      end
   end

   // Compare both instances against the model head every falling edge
   always @(negedge clk) begin
      logic [53:0] e_s;
      logic [53:0] e_z;
      e_s = '0;
      e_z = '0;
      if (q.size() != 0) begin
         e_s = model(q[0], 1'b1);
         e_z = model(q[0], 1'b0);
      end
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() != DEPTH});
      chk("head_sext", {out_type, out_src1, out_src2, out_dest, out_cond, out_imm}, e_s);
      chk("out_valid_z", {63'd0, out_valid_z}, {63'd0, q.size() != 0});
      chk("in_ready_z", {63'd0, in_ready_z}, {63'd0, q.size() != DEPTH});
      chk("head_zext", {out_type_z, out_src1_z, out_src2_z, out_dest_z, out_cond_z, out_imm_z}, e_z);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] inst;
      logic [1:0]  t;
      logic [4:0]  s1, s2, d, c;
      logic [31:0] imm_s;
      logic [31:0] imm_z;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{32'h800100C2, 2'd2, 5'd3,  5'd0, 5'd1, 5'd0, 32'hFFFF8001, 32'h00008001};
      vecs[1] = '{32'h00093901, 2'd1, 5'd4,  5'd7, 5'd9, 5'd0, 32'h00000000, 32'h00000000};
      vecs[2] = '{32'h00102883, 2'd3, 5'd2,  5'd0, 5'd0, 5'd5, 32'h00000010, 32'h00000010};
      vecs[3] = '{32'hFFFFFFC0, 2'd0, 5'd31, 5'd0, 5'd0, 5'd0, 32'h00000000, 32'h00000000};
      vecs[4] = '{32'hFFFF3FC3, 2'd3, 5'd31, 5'd0, 5'd0, 5'd7, 32'hFFFFFFFF, 32'h0000FFFF};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; out_ready = 1'b0;
      #1;
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      #20;
      step();
      rst_n = 1'b1;
      step();

      // Single-instruction decode table, one push then one pop each
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_inst = vecs[k].inst; out_ready = 1'b1;
         step();
         in_valid = 1'b0;
         chk("vec_valid", {63'd0, out_valid}, 64'd1);
         chk("vec_fields", {out_type, out_src1, out_src2, out_dest, out_cond, out_imm},
             {vecs[k].t, vecs[k].s1, vecs[k].s2, vecs[k].d, vecs[k].c, vecs[k].imm_s});
         chk("vec_imm_zext", {32'd0, out_imm_z}, {32'd0, vecs[k].imm_z});
         step();
         chk("vec_drained", {63'd0, out_valid}, 64'd0);
      end

      // Back-pressure: third push held until a slot frees
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h00093901; step();
      in_inst = 32'h00102883; step();
      in_inst = 32'h800100C2;
      chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
      step();
      chk("bp_still_full", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      step();
      chk("bp_slot_free", {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      chk("bp_third_head", {58'd0, out_type, out_src1}, {58'd0, 2'd2, 5'd3});
      step();
      chk("bp_empty", {63'd0, out_valid}, 64'd0);

      // Flush while full with push and pop both requested
      out_ready = 1'b0; in_valid = 1'b1;
      in_inst = 32'h00093901; step();
      in_inst = 32'h00102883; step();
      chk("flush_pre_full", {63'd0, in_ready}, 64'd0);
      flush = 1'b1; out_ready = 1'b1; in_inst = 32'hFFFFFFC0;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_ready", {63'd0, in_ready}, 64'd1);
      step();

      // Continuous streaming, pointers wrap several times
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; in_inst = $urandom;
         step();
         chk("stream_valid", {63'd0, out_valid}, 64'd1);
         chk("stream_ready", {63'd0, in_ready}, 64'd1);
      end
      in_valid = 1'b0;
      step();
      chk("stream_drained", {63'd0, out_valid}, 64'd0);

      // Asynchronous reset mid-stream, checked before the next edge
      in_valid = 1'b1; in_inst = 32'h800100C2; step();
      in_inst = 32'h00093901; step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_valid", {63'd0, out_valid}, 64'd0);
      chk("areset_fields", {out_type, out_src1, out_src2, out_dest, out_cond, out_imm}, 64'd0);
      chk("areset_ready", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("post_reset_empty", {63'd0, out_valid}, 64'd0);
      in_valid = 1'b1; in_inst = 32'h00102883; step();
      in_valid = 1'b0;
      chk("post_reset_head", {58'd0, out_type, out_src1}, {58'd0, 2'd3, 5'd2});
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
